// File: rtl/pos_sweep_checker.sv
// Exhaustive 4-input sweep: drives idx on {X,Y,W,Z}, captures S1 into a truth table and
// counts S1 ones and S1/S2 disagreements, recording the lowest disagreeing index.
module pos_sweep_checker #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        S1,
  input  logic        S2,
  output logic        X,
  output logic        Y,
  output logic        W,
  output logic        Z,
  output logic        busy,
  output logic        done,
  output logic [15:0] truth,
  output logic [4:0]  ones_count,
  output logic [4:0]  mismatch_count,
  output logic        any_bad,
  output logic [3:0]  first_bad
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] HOLD_LAST = 3'(SETTLE);

  state_t      r_state;
  logic [3:0]  r_idx;
  logic [2:0]  r_hold;
  logic [3:0]  r_vec;
  logic        r_busy;
  logic        r_done;
  logic [15:0] r_truth;
  logic [4:0]  r_ones;
  logic [4:0]  r_mis;
  logic        r_any;
  logic [3:0]  r_first;

  logic w_sample;
  logic w_diff;

  // The sample edge is the one closing the last of the SETTLE+1 hold cycles.
  assign w_sample = (r_state == RUN) && (r_hold == HOLD_LAST);
  assign w_diff   = S1 ^ S2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_idx   <= 4'd0;
      r_hold  <= 3'd0;
      r_vec   <= 4'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_truth <= 16'h0000;
      r_ones  <= 5'd0;
      r_mis   <= 5'd0;
      r_any   <= 1'b0;
      r_first <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_idx   <= 4'd0;
            r_hold  <= 3'd0;
            r_vec   <= 4'd0;
            r_truth <= 16'h0000;
            r_ones  <= 5'd0;
            r_mis   <= 5'd0;
            r_any   <= 1'b0;
            r_first <= 4'd0;
          end
        end
        RUN: begin
          if (w_sample) begin
            r_hold         <= 3'd0;
            r_truth[r_idx] <= S1;
            r_ones         <= r_ones + {4'd0, S1};
            if (w_diff) begin
              r_mis <= r_mis + 5'd1;
              if (!r_any) begin
                r_any   <= 1'b1;
                r_first <= r_idx;
              end
            end
            // Leave RUN instead of wrapping idx back to 0.
            if (r_idx == 4'd15) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_vec   <= 4'd0;
            end else begin
              r_idx <= r_idx + 4'd1;
              r_vec <= r_idx + 4'd1;
            end
          end else begin
            r_hold <= r_hold + 3'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_vec   <= 4'd0;
        end
      endcase
    end
  end

  assign X              = r_vec[3];
  assign Y              = r_vec[2];
  assign W              = r_vec[1];
  assign Z              = r_vec[0];
  assign busy           = r_busy;
  assign done           = r_done;
  assign truth          = r_truth;
  assign ones_count     = r_ones;
  assign mismatch_count = r_mis;
  assign any_bad        = r_any;
  assign first_bad      = r_first;

endmodule

// File: tb/tb_pos_sweep_checker.sv
// Scoreboarded bench for pos_sweep_checker at SETTLE=1 and SETTLE=3 against
// F = PI M(1,2,5,13,14,15), with faulty S2 variants, mid-run reset and held start.
module tb_pos_sweep_checker;

  typedef struct {
    logic [15:0] truth;
    logic [4:0]  ones;
    logic [4:0]  mis;
    logic        any;
    logic [3:0]  first;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset1, start1, s1_1, s2_1, x1, y1, w1, z1, busy1, done1, any1;
  logic [15:0] truth1;
  logic [4:0]  ones1, mis1;
  logic [3:0]  first1;
  logic reset3, start3, s1_3, s2_3, x3, y3, w3, z3, busy3, done3, any3;
  logic [15:0] truth3;
  logic [4:0]  ones3, mis3;
  logic [3:0]  first3;

  int mode1 = 0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  exp_t q1[$];
  exp_t q3[$];

  // Canonical product of maxterms: each maxterm is 0 only at its own index.
  function automatic logic pos_f(input logic [3:0] v);
    return (v != 4'd1) && (v != 4'd2) && (v != 4'd5) &&
           (v != 4'd13) && (v != 4'd14) && (v != 4'd15);
  endfunction

  // Hand-minimised PoS: (Y'+W+Z')(X'+Y'+Z')(X'+Y'+W')(X+W+Z')(X+Y+W'+Z)
  function automatic logic simp_f(input logic [3:0] v);
    logic a, b, c, d;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    return (!b | c | !d) & (!a | !b | !d) & (!a | !b | !c) & (a | c | !d) & (a | b | !c | d);
  endfunction

  function automatic logic s2_of(input int mode, input logic [3:0] v);
    case (mode)
      1:       return 1'b0;
      2:       return (v == 4'd7) ? ~pos_f(v) : pos_f(v);
      default: return simp_f(v);
    endcase
  endfunction

  assign s1_1 = pos_f({x1, y1, w1, z1});
  assign s2_1 = s2_of(mode1, {x1, y1, w1, z1});
  assign s1_3 = pos_f({x3, y3, w3, z3});
  assign s2_3 = simp_f({x3, y3, w3, z3});

  pos_sweep_checker #(.SETTLE(1)) u_dut1 (
    .clk(clk), .reset(reset1), .start(start1), .S1(s1_1), .S2(s2_1),
    .X(x1), .Y(y1), .W(w1), .Z(z1), .busy(busy1), .done(done1),
    .truth(truth1), .ones_count(ones1), .mismatch_count(mis1),
    .any_bad(any1), .first_bad(first1)
  );

  pos_sweep_checker #(.SETTLE(3)) u_dut3 (
    .clk(clk), .reset(reset3), .start(start3), .S1(s1_3), .S2(s2_3),
    .X(x3), .Y(y3), .W(w3), .Z(z3), .busy(busy3), .done(done3),
    .truth(truth3), .ones_count(ones3), .mismatch_count(mis3),
    .any_bad(any3), .first_bad(first3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: latency measured from the first busy cycle to the done cycle.
  int   st1 = 0, st3 = 0;
  logic pb1 = 1'b0, pb3 = 1'b0;
  exp_t e1, e3;

  always @(negedge clk) begin
    if (busy1 && !pb1) st1 = cyc;
    pb1 = busy1;
    if (done1) begin
      if (q1.size() == 0) begin
        chk("dut1_unexpected_done", 32'd1, 32'd0);
      end else begin
        e1 = q1.pop_front();
        chk("dut1_latency", cyc - st1 + 1, e1.lat);
        chk("dut1_truth", {16'd0, truth1}, {16'd0, e1.truth});
        chk("dut1_ones", {27'd0, ones1}, {27'd0, e1.ones});
        chk("dut1_mismatch", {27'd0, mis1}, {27'd0, e1.mis});
        chk("dut1_any_bad", {31'd0, any1}, {31'd0, e1.any});
        chk("dut1_first_bad", {28'd0, first1}, {28'd0, e1.first});
      end
    end
  end

  always @(negedge clk) begin
    if (busy3 && !pb3) st3 = cyc;
    pb3 = busy3;
    if (done3) begin
      if (q3.size() == 0) begin
        chk("dut3_unexpected_done", 32'd1, 32'd0);
      end else begin
        e3 = q3.pop_front();
        chk("dut3_latency", cyc - st3 + 1, e3.lat);
        chk("dut3_truth", {16'd0, truth3}, {16'd0, e3.truth});
        chk("dut3_ones", {27'd0, ones3}, {27'd0, e3.ones});
        chk("dut3_mismatch", {27'd0, mis3}, {27'd0, e3.mis});
        chk("dut3_any_bad", {31'd0, any3}, {31'd0, e3.any});
        chk("dut3_first_bad", {28'd0, first3}, {28'd0, e3.first});
      end
    end
  end

  task automatic wait_done(input int which, input int maxc);
    int n;
    n = 0;
    while (n < maxc) begin
      @(negedge clk);
      if ((which == 1) ? done1 : done3) break;
      n++;
    end
    if (n >= maxc) chk("done_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_state1(input string tag);
    chk({tag, "_vec"}, {28'd0, x1, y1, w1, z1}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy1}, 32'd0);
    chk({tag, "_done"}, {31'd0, done1}, 32'd0);
    chk({tag, "_truth"}, {16'd0, truth1}, 32'd0);
    chk({tag, "_counts"}, {22'd0, ones1, mis1}, 32'd0);
    chk({tag, "_bad"}, {27'd0, any1, first1}, 32'd0);
  endtask

  task automatic pulse_start1;
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
  endtask

  initial begin
    reset1 = 1'b1; start1 = 1'b0;
    reset3 = 1'b1; start3 = 1'b0;
    repeat (3) @(negedge clk);
    reset1 = 1'b0; reset3 = 1'b0;
    check_reset_state1("reset");
    chk("reset3_busy_done", {30'd0, busy3, done3}, 32'd0);
    chk("reset3_truth", {16'd0, truth3}, 32'd0);

    // Matching implementations; also check per-vector hold timing.
    mode1 = 0;
    q1.push_back('{16'h1FD9, 5'd10, 5'd0, 1'b0, 4'd0, 33});
    pulse_start1();
    chk("run_busy", {31'd0, busy1}, 32'd1);
    chk("run_vec0_a", {28'd0, x1, y1, w1, z1}, 32'd0);
    @(negedge clk);
    chk("run_vec0_b", {28'd0, x1, y1, w1, z1}, 32'd0);
    @(negedge clk);
    chk("run_vec1", {28'd0, x1, y1, w1, z1}, 32'd1);
    wait_done(1, 100);
    @(negedge clk);
    chk("after_done_pulse", {30'd0, done1, busy1}, 32'd0);
    chk("after_done_vec", {28'd0, x1, y1, w1, z1}, 32'd0);
    repeat (3) @(negedge clk);
    chk("idle_hold_truth", {16'd0, truth1}, 32'h1FD9);
    chk("idle_hold_ones", {27'd0, ones1}, 32'd10);

    // S2 stuck at 0: every S1 one is a mismatch, first at index 0.
    mode1 = 1;
    q1.push_back('{16'h1FD9, 5'd10, 5'd10, 1'b1, 4'd0, 33});
    pulse_start1();
    wait_done(1, 100);
    repeat (2) @(negedge clk);

    // S2 inverted only at vector 7.
    mode1 = 2;
    q1.push_back('{16'h1FD9, 5'd10, 5'd1, 1'b1, 4'd7, 33});
    pulse_start1();
    wait_done(1, 100);
    repeat (2) @(negedge clk);

    // Reset at idx=5, with start asserted alongside: reset wins, no done.
    mode1 = 0;
    pulse_start1();
    for (int i = 0; i < 100; i++) begin
      if ({x1, y1, w1, z1} == 4'd5) break;
      @(negedge clk);
    end
    chk("reached_idx5", {28'd0, x1, y1, w1, z1}, 32'd5);
    reset1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    reset1 = 1'b0; start1 = 1'b0;
    check_reset_state1("midrun_reset");
    repeat (40) @(negedge clk);
    chk("no_restart_after_reset", {31'd0, busy1}, 32'd0);
    q1.push_back('{16'h1FD9, 5'd10, 5'd0, 1'b0, 4'd0, 33});
    pulse_start1();
    wait_done(1, 100);
    repeat (2) @(negedge clk);

    // Start held high, re-pulsed mid-run: one run, then a fresh one from IDLE.
    q1.push_back('{16'h1FD9, 5'd10, 5'd0, 1'b0, 4'd0, 33});
    q1.push_back('{16'h1FD9, 5'd10, 5'd0, 1'b0, 4'd0, 33});
    @(negedge clk) start1 = 1'b1;
    repeat (10) @(negedge clk);
    start1 = 1'b0;
    @(negedge clk) start1 = 1'b1;
    wait_done(1, 100);
    @(negedge clk);
    chk("held_start_idle_gap", {31'd0, busy1}, 32'd0);
    @(negedge clk);
    chk("held_start_rerun", {31'd0, busy1}, 32'd1);
    start1 = 1'b0;
    wait_done(1, 100);
    repeat (2) @(negedge clk);

    // SETTLE=3 instance: 4-cycle hold per vector.
    q3.push_back('{16'h1FD9, 5'd10, 5'd0, 1'b0, 4'd0, 65});
    @(negedge clk) start3 = 1'b1;
    @(negedge clk) start3 = 1'b0;
    wait_done(3, 200);
    repeat (3) @(negedge clk);

    chk("q1_drained", q1.size(), 32'd0);
    chk("q3_drained", q3.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
